// File: rtl/parity_link_ctrl.sv
// rtl/parity_link_ctrl.sv - nibble serial link: framed TX with parity, RX deframer with error counter
module parity_link_ctrl #(
    parameter int BIT_CYCLES = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [3:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    input  logic                 rx_serial,
    output logic [3:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [1:0]  tx_idx_q, tx_idx_d;
    logic [3:0]  tx_shreg_q, tx_shreg_d;
    logic        tx_par_q, tx_par_d;
    logic        tx_en_q;

    // tx_en_q holds tx_ready low for the first cycle after reset is released
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            tx_en_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            tx_en_q    <= 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + CNT_ONE;
        tx_idx_d   = tx_idx_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        tx_serial  = 1'b1;
        tx_ready   = (tx_state_q == TX_IDLE) && tx_en_q;
        tx_busy    = (tx_state_q != TX_IDLE);
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid && tx_ready) begin
                    tx_state_d = TX_START;
                    tx_idx_d   = '0;
                    tx_shreg_d = tx_data;
                    tx_par_d   = (^tx_data) ^ mode;
                end
            end
            TX_START: begin
                tx_serial = 1'b0;
                if (tx_cnt_q == CNT_LAST) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_serial = tx_shreg_q[tx_idx_q];
                if (tx_cnt_q == CNT_LAST) begin
                    tx_idx_d = tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) tx_state_d = TX_PARITY;
                end
            end
            TX_PARITY: begin
                tx_serial = tx_par_q;
                if (tx_cnt_q == CNT_LAST) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    rx_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [1:0]  rx_idx_q, rx_idx_d;
    logic [3:0]  rx_shreg_q, rx_shreg_d;
    logic        rx_pbit_q, rx_pbit_d;
    logic        rx_mode_q, rx_mode_d;
    logic [3:0]  rx_data_q;
    logic        rx_perr_q, rx_ferr_q, rx_valid_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic        rx_done, rx_perr_calc, rx_ferr_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shreg_q <= '0;
            rx_pbit_q  <= 1'b0;
            rx_mode_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shreg_q <= rx_shreg_d;
            rx_pbit_q  <= rx_pbit_d;
            rx_mode_q  <= rx_mode_d;
            rx_valid_q <= rx_done;
            if (rx_done) begin
                rx_data_q <= rx_shreg_q;
                rx_perr_q <= rx_perr_calc;
                rx_ferr_q <= rx_ferr_calc;
            end
            if (err_clr)
                err_q <= '0;
            else if (rx_done && (rx_perr_calc || rx_ferr_calc) && (err_q != '1))
                err_q <= err_q + 1'b1;
        end
    end

    // rx_cnt_q is the offset inside the current bit; the start cycle t0 counts as offset 0
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + CNT_ONE;
        rx_idx_d     = rx_idx_q;
        rx_shreg_d   = rx_shreg_q;
        rx_pbit_d    = rx_pbit_q;
        rx_mode_d    = rx_mode_q;
        rx_done      = 1'b0;
        rx_perr_calc = (^rx_shreg_q) ^ rx_pbit_q ^ rx_mode_q;
        rx_ferr_calc = ~rx_serial;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CNT_ONE;
                if (!rx_serial) begin
                    rx_state_d = RX_START;
                    rx_mode_d  = mode;
                end
            end
            RX_START: begin
                rx_idx_d = '0;
                if (rx_cnt_q == CNT_HALF && rx_serial) rx_state_d = RX_IDLE;
                else if (rx_cnt_q == CNT_LAST)         rx_state_d = RX_DATA;
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_HALF) rx_shreg_d = {rx_serial, rx_shreg_q[3:1]};
                if (rx_cnt_q == CNT_LAST) begin
                    rx_idx_d = rx_idx_q + 2'd1;
                    if (rx_idx_q == 2'd3) rx_state_d = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == CNT_HALF) rx_pbit_d = rx_serial;
                if (rx_cnt_q == CNT_LAST) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_done    = 1'b1;
                    rx_state_d = rx_serial ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_serial) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign err_count     = err_q;
endmodule

// File: tb/tb_parity_link_ctrl.sv
// tb/tb_parity_link_ctrl.sv - self-checking bench for parity_link_ctrl with a frame-level reference model
module tb_parity_link_ctrl;
    localparam int BC = 4;
    localparam int EW = 2;
    localparam int FRAME = 7 * BC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic [3:0]    tx_data = 4'h0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx_serial, tx_busy;
    logic          rx_loop = 1'b1;
    logic          rx_man = 1'b1;
    logic          rx_serial;
    logic [3:0]    rx_data;
    logic          rx_valid, rx_parity_err, rx_frame_err;
    logic          err_clr = 1'b0;
    logic [EW-1:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    assign rx_serial = rx_loop ? tx_serial : rx_man;

    parity_link_ctrl #(.BIT_CYCLES(BC), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_serial(tx_serial), .tx_busy(tx_busy),
        .rx_serial(rx_serial), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // bit k of the result is line bit k: start, d0..d3, parity, stop
    function automatic logic [6:0] frame_bits(input logic [3:0] d, input logic m,
                                              input logic stopb, input logic flip_par);
        logic p;
        p = (d[0] ^ d[1] ^ d[2] ^ d[3]);
        if (m) p = ~p;
        p = p ^ flip_par;
        return {stopb, p, d[3], d[2], d[1], d[0], 1'b0};
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= (1 << EW) - 1) ? (1 << EW) - 1 : c + 1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
    endtask

    task automatic watch_tx(input logic [3:0] d, input logic m, input bit disturb,
                            output int np, output logic [3:0] rd, output logic rpe, output logic rfe);
        logic [6:0] fb;
        int bad;
        logic got_s, want_s;
        fb = frame_bits(d, m, 1'b1, 1'b0);
        bad = -1; np = 0; rd = 4'hx; rpe = 1'bx; rfe = 1'bx;
        got_s = 1'b0; want_s = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (bad < 0 && (tx_serial !== fb[i / BC] || tx_busy !== 1'b1 || tx_ready !== 1'b0)) begin
                bad = i; got_s = tx_serial; want_s = fb[i / BC];
            end
            if (rx_valid === 1'b1) begin
                np++; rd = rx_data; rpe = rx_parity_err; rfe = rx_frame_err;
            end
            if (disturb && i == 1) begin
                mode = ~m;
                tx_data = 4'($urandom);
            end
            step();
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL tx_frame d=%b m=%0d: cycle %0d tx_serial=%b required %b (busy=%b ready=%b)",
                     d, m, bad, got_s, want_s, tx_busy, tx_ready);
        end
    endtask

    task automatic drive_rx(input logic [6:0] fb, input int extra_low, input int clr_at, input int tail,
                            output int np, output logic [3:0] rd, output logic rpe, output logic rfe);
        np = 0; rd = 4'hx; rpe = 1'bx; rfe = 1'bx;
        for (int i = 0; i < FRAME + extra_low + tail; i++) begin
            rx_man  = (i < FRAME) ? fb[i / BC] : (i < FRAME + extra_low) ? 1'b0 : 1'b1;
            err_clr = (i == clr_at);
            if (rx_valid === 1'b1) begin
                np++; rd = rx_data; rpe = rx_parity_err; rfe = rx_frame_err;
            end
            step();
        end
        err_clr = 1'b0;
        rx_man  = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({tx_serial, tx_ready, tx_busy, rx_valid, rx_parity_err, rx_frame_err, rx_data, err_count}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, {EW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: ser=%b rdy=%b busy=%b vld=%b pe=%b fe=%b data=%h cnt=%0d required 1 0 0 0 0 0 0 0",
                     tx_serial, tx_ready, tx_busy, rx_valid, rx_parity_err, rx_frame_err, rx_data, err_count);
        end
        rst = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: tx_ready=%b required 0", tx_ready);
        end
        step();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: tx_ready=%b required 1", tx_ready);
        end
    endtask

    task automatic test_even_loopback;
        int np; logic [3:0] rd; logic pe, fe;
        rx_loop = 1'b1; mode = 1'b0;
        wait_ready();
        tx_data = 4'b1011; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        watch_tx(4'b1011, 1'b0, 1'b0, np, rd, pe, fe);
        checks++;
        if (np !== 1 || rd !== 4'b1011 || pe !== 1'b0 || fe !== 1'b0 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL even_rx: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 1011 0 0 %0d",
                     np, rd, pe, fe, err_count, exp_err);
        end
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL even_idle: rdy=%b busy=%b ser=%b required 1 0 1", tx_ready, tx_busy, tx_serial);
        end
    endtask

    task automatic test_back_to_back;
        int np; logic [3:0] rd; logic pe, fe;
        rx_loop = 1'b1; mode = 1'b1;
        wait_ready();
        tx_data = 4'b0000; tx_valid = 1'b1;
        step();
        tx_data = 4'b1111;
        watch_tx(4'b0000, 1'b1, 1'b0, np, rd, pe, fe);
        checks++;
        if (np !== 1 || rd !== 4'b0000 || pe !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rx0: pulses=%0d data=%b pe=%b fe=%b required 1 0000 0 0", np, rd, pe, fe);
        end
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: rdy=%b busy=%b required 1 0", tx_ready, tx_busy);
        end
        step();
        tx_valid = 1'b0;
        watch_tx(4'b1111, 1'b1, 1'b0, np, rd, pe, fe);
        checks++;
        if (np !== 1 || rd !== 4'b1111 || pe !== 1'b0 || fe !== 1'b0 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL b2b_rx1: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 1111 0 0 %0d",
                     np, rd, pe, fe, err_count, exp_err);
        end
    endtask

    task automatic test_parity_error;
        int np; logic [3:0] rd; logic pe, fe;
        rx_loop = 1'b0; mode = 1'b0;
        drive_rx(frame_bits(4'b0110, 1'b0, 1'b1, 1'b1), 0, -1, 4, np, rd, pe, fe);
        exp_err = sat_inc(exp_err);
        checks++;
        if (np !== 1 || rd !== 4'b0110 || pe !== 1'b1 || fe !== 1'b0 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL parity_err: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 0110 1 0 %0d",
                     np, rd, pe, fe, err_count, exp_err);
        end
    endtask

    task automatic test_frame_error;
        int np; logic [3:0] rd; logic pe, fe; logic [3:0] d; logic m;
        rx_loop = 1'b0;
        d = 4'($urandom); m = 1'($urandom); mode = m;
        drive_rx(frame_bits(d, m, 1'b0, 1'b0), 10 - BC, -1, 4, np, rd, pe, fe);
        exp_err = sat_inc(exp_err);
        checks++;
        if (np !== 1 || rd !== d || pe !== 1'b0 || fe !== 1'b1 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL frame_err: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 %b 0 1 %0d",
                     np, rd, pe, fe, err_count, d, exp_err);
        end
        d = 4'($urandom); m = 1'($urandom); mode = m;
        drive_rx(frame_bits(d, m, 1'b1, 1'b0), 0, -1, 4, np, rd, pe, fe);
        checks++;
        if (np !== 1 || rd !== d || pe !== 1'b0 || fe !== 1'b0 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL after_wait_high: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 %b 0 0 %0d",
                     np, rd, pe, fe, err_count, d, exp_err);
        end
    endtask

    task automatic test_false_start;
        int np;
        rx_loop = 1'b0; np = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            rx_man = (i == 0) ? 1'b0 : 1'b1;
            if (rx_valid === 1'b1) np++;
            step();
        end
        checks++;
        if (np !== 0 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL false_start: pulses=%0d cnt=%0d required 0 %0d", np, err_count, exp_err);
        end
    endtask

    task automatic test_random_loopback;
        int np; logic [3:0] rd; logic pe, fe; logic [3:0] d; logic m;
        rx_loop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = 4'($urandom); m = 1'($urandom);
            mode = m;
            wait_ready();
            tx_data = d; tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            watch_tx(d, m, 1'b1, np, rd, pe, fe);
            checks++;
            if (np !== 1 || rd !== d || pe !== 1'b0 || fe !== 1'b0 || err_count !== EW'(exp_err)) begin
                errors++;
                $display("FAIL rand_loop[%0d]: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 %b 0 0 %0d",
                         k, np, rd, pe, fe, err_count, d, exp_err);
            end
        end
    endtask

    task automatic test_random_rx;
        int np; logic [3:0] rd; logic pe, fe; logic [3:0] d; logic m, fp, sb;
        rx_loop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d = 4'($urandom); m = 1'($urandom); fp = 1'($urandom); sb = 1'($urandom);
            mode = m;
            drive_rx(frame_bits(d, m, sb, fp), sb ? 0 : 3, -1, 3, np, rd, pe, fe);
            if (fp || !sb) exp_err = sat_inc(exp_err);
            checks++;
            if (np !== 1 || rd !== d || pe !== fp || fe !== ~sb || err_count !== EW'(exp_err)) begin
                errors++;
                $display("FAIL rand_rx[%0d]: pulses=%0d data=%b pe=%b fe=%b cnt=%0d required 1 %b %b %b %0d",
                         k, np, rd, pe, fe, err_count, d, fp, ~sb, exp_err);
            end
        end
    endtask

    task automatic test_saturation;
        int np; logic [3:0] rd; logic pe, fe; logic [3:0] d;
        rx_loop = 1'b0; mode = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err = 0;
        checks++;
        if (err_count !== '0) begin
            errors++;
            $display("FAIL err_clr: cnt=%0d required 0", err_count);
        end
        for (int k = 0; k < 5; k++) begin
            d = 4'($urandom);
            drive_rx(frame_bits(d, 1'b0, 1'b1, 1'b1), 0, -1, 2, np, rd, pe, fe);
            exp_err = sat_inc(exp_err);
            checks++;
            if (np !== 1 || pe !== 1'b1 || err_count !== EW'(exp_err)) begin
                errors++;
                $display("FAIL saturate[%0d]: pulses=%0d pe=%b cnt=%0d required 1 1 %0d",
                         k, np, pe, err_count, exp_err);
            end
        end
        drive_rx(frame_bits(4'b1001, 1'b0, 1'b1, 1'b1), 0, 6 * BC + BC / 2, 2, np, rd, pe, fe);
        exp_err = 0;
        checks++;
        if (np !== 1 || pe !== 1'b1 || err_count !== EW'(exp_err)) begin
            errors++;
            $display("FAIL clr_priority: pulses=%0d pe=%b cnt=%0d required 1 1 0", np, pe, err_count);
        end
    endtask

    task automatic test_reset_mid_tx;
        int np;
        rx_loop = 1'b1; mode = 1'b0;
        wait_ready();
        tx_data = 4'($urandom); tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (tx_serial !== 1'b1 || tx_ready !== 1'b0 || tx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ser=%b rdy=%b busy=%b vld=%b required 1 0 0 0",
                     tx_serial, tx_ready, tx_busy, rx_valid);
        end
        rst = 1'b0;
        step();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: tx_ready=%b required 1", tx_ready);
        end
        np = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (rx_valid === 1'b1 || tx_serial !== 1'b1) np++;
            step();
        end
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: %0d active cycles, required 0", np);
        end
    endtask

    initial begin
        test_reset();
        test_even_loopback();
        test_back_to_back();
        test_parity_error();
        test_frame_error();
        test_false_start();
        test_random_loopback();
        test_random_rx();
        test_saturation();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_link_ctrl.md
Name: parity_link_ctrl

Overview:
- Serial link controller around the nibble parity generator/checker.
- TX side: accepts 4-bit words over a valid/ready handshake, appends an even/odd parity bit, and shifts out a framed serial stream.
- RX side: deframes an incoming stream, checks parity and stop bit, and keeps a saturating error counter.
- Sits between a nibble-wide producer/consumer and a single-wire link; TX and RX are independent, and a bench may loop tx_serial back to rx_serial.

Parameters:
- BIT_CYCLES, 4, clocks per serial bit; legal values are >= 2.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- mode  input  1  0 = even parity, 1 = odd parity; sampled per frame (see Behaviour).
- tx_data  input  4  word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  controller can accept a word.
- tx_serial  output  1  serial line out; idles high.
- tx_busy  output  1  frame in progress.
- rx_serial  input  1  serial line in, synchronous to clk.
- rx_data  output  4  last received word.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- rx_parity_err  output  1  parity mismatch on the frame; qualified by rx_valid.
- rx_frame_err  output  1  stop bit sampled 0; qualified by rx_valid.
- err_clr  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  count of errored frames, saturating.

Behaviour:

Frame format:
- Order on the line: start (0), d0, d1, d2, d3 (LSB first), parity, stop (1).
- 7 bits; each bit lasts BIT_CYCLES clocks.
- Parity bit: mode 0 gives XOR of data; mode 1 gives XNOR of data.

Reset (rst high at a clock edge):
- tx_serial=1, tx_ready=0, tx_busy=0.
- rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_data=0, err_count=0.
- Both FSMs go to IDLE.
- tx_ready rises on the first edge after rst falls.
- Reset mid-frame aborts the frame immediately: no rx_valid, tx_serial=1 the next cycle.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- tx_ready=1 only in IDLE; tx_busy = not IDLE.
- Accept happens on an edge with tx_valid && tx_ready. At that edge:
  - latch tx_data and mode, and compute parity;
  - move to START; tx_ready=0 from the next cycle.
- A bit counter runs 0..BIT_CYCLES-1 per bit; a bit index runs 0..3 in DATA.
- After the last STOP clock, return to IDLE (tx_serial=1, tx_ready=1).
- Frame occupies exactly 7*BIT_CYCLES clocks.
- Back-to-back frames are separated by at least one IDLE cycle.
- tx_data and mode changes while busy have no effect.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- Start detection: in IDLE, the first cycle with rx_serial=0 is t0. At t0:
  - latch mode;
  - go to START.
- Sample points: bit k (0=start … 6=stop) is sampled at t0 + k*BIT_CYCLES + BIT_CYCLES/2 (integer division).
- False start: start sample = 1 returns the FSM to IDLE, with no outputs and no count.
- Data and parity: data samples shift in LSB first; then parity is sampled.
- At the stop-sample edge:
  - rx_data is updated;
  - rx_parity_err = XOR(data, parity) for mode 0, XNOR for mode 1;
  - rx_frame_err = (stop==0);
  - rx_valid=1 for exactly that following cycle.
- Next state after the stop sample:
  - stop=1: go to IDLE;
  - stop=0: go to WAIT_HIGH, and stay there until rx_serial=1, then go to IDLE.
- rx_data and the error flags hold until the next completed frame.

err_count:
- +1 on each completed frame with rx_parity_err or rx_frame_err. One increment per frame even if both errors are set.
- Saturates at all-ones.
- err_clr has priority over a same-cycle increment: the count goes to 0 and that error is not counted.

Test Plan:
1. Even parity, BIT_CYCLES=4, loopback, send 4'b1011 -> tx_serial 0,1,1,0,1,1,1 each held 4 clocks (28 total). rx_valid pulses once with rx_data=1011, rx_parity_err=0, rx_frame_err=0, err_count=0.
2. Odd parity, send 4'b0000 then 4'b1111 with tx_valid held high -> parity bits 1 and 1. Second accept occurs exactly one IDLE cycle after the first frame ends. Both frames received error-free.
3. Loopback with the parity bit inverted on the wire, even mode, data 4'b0110 -> rx_data=0110, rx_parity_err=1, err_count=1.
4. Stop bit driven 0 and held low for 10 clocks -> rx_frame_err=1 and err_count increments. No new frame starts until rx_serial returns to 1; a valid frame afterwards is received cleanly.
5. rx_serial low for 1 clock only (BIT_CYCLES=4) -> false start: no rx_valid, err_count unchanged.
6. ERR_CNT_W=2, five errored frames -> err_count sticks at 3. Then err_clr coincident with a sixth error -> err_count=0. Then rst asserted mid-TX-frame -> tx_serial=1 next cycle, tx_ready=1 one cycle after rst drops.
